// File: rtl/imm_encoder_pipe.sv
// Packs a signed immediate into the RISC-V I/S/B/U/J fields of a base instruction word.
// Two-stage valid/ready pipeline; define ERR_COUNT_EN to add the saturating err_count port.
module imm_encoder_pipe #(
  parameter int CNT_W       = 8,
  parameter bit DROP_ON_ERR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type_sel,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_range_err,
  output logic        out_align_err
`ifdef ERR_COUNT_EN
  ,output logic [CNT_W-1:0] err_count
`endif
);

  localparam logic [2:0] T_I = 3'd0, T_S = 3'd1, T_B = 3'd2, T_U = 3'd3, T_J = 3'd4;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        range_err;
    logic        align_err;
  } rsp_t;

  logic  rdy_q, rdy_d;
  logic  s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  req_t  s1_q, s1_d;
  rsp_t  s2_q, s2_d, pk;
  logic  s1_en, s2_en, accept, s1_err;
  logic [31:0] imm;
  logic  fit_is, fit_b, fit_j;

  assign imm    = s1_q.imm;
  // An immediate fits N signed bits when every bit above bit N-1 equals the sign bit.
  assign fit_is = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit_b  = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit_j  = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    pk.instr     = s1_q.base;
    pk.range_err = 1'b0;
    pk.align_err = 1'b0;
    case (s1_q.typ)
      T_I: begin
        pk.instr[31:20] = imm[11:0];
        pk.range_err    = ~fit_is;
      end
      T_S: begin
        pk.instr[31:25] = imm[11:5];
        pk.instr[11:7]  = imm[4:0];
        pk.range_err    = ~fit_is;
      end
      T_B: begin
        pk.instr[31]    = imm[12];
        pk.instr[7]     = imm[11];
        pk.instr[30:25] = imm[10:5];
        pk.instr[11:8]  = imm[4:1];
        pk.range_err    = ~fit_b;
        pk.align_err    = imm[0];
      end
      T_U: begin
        pk.instr[31:12] = imm[31:12];
        pk.align_err    = |imm[11:0];
      end
      T_J: begin
        pk.instr[31]    = imm[20];
        pk.instr[30:21] = imm[10:1];
        pk.instr[20]    = imm[11];
        pk.instr[19:12] = imm[19:12];
        pk.range_err    = ~fit_j;
        pk.align_err    = imm[0];
      end
      default: pk.range_err = 1'b1;
    endcase
  end

  assign s1_err = pk.range_err | pk.align_err;

  always_comb begin
    s2_en  = ~s2_v_q | out_ready;
    s1_en  = ~s1_v_q | s2_en;
    // rdy_q keeps the input closed until the first edge after reset release
    in_ready = s1_en & rdy_q;
    accept   = in_valid & in_ready;
    rdy_d    = 1'b1;
    s1_v_d   = s1_en ? accept : s1_v_q;
    s1_d     = accept ? '{typ: in_type_sel, imm: in_imm, base: in_base} : s1_q;
    s2_v_d   = s2_en ? (s1_v_q & ~(DROP_ON_ERR & s1_err)) : s2_v_q;
    s2_d     = (s2_en & s1_v_q) ? pk : s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      rdy_q  <= rdy_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign out_valid     = s2_v_q;
  assign out_instr     = s2_q.instr;
  assign out_range_err = s2_q.range_err;
  assign out_align_err = s2_q.align_err;

`ifdef ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counted as the item leaves S1, so dropped items are included.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s1_v_q && s2_en && s1_err && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder_pipe.sv
// Randomized + directed bench for imm_encoder_pipe; a second instance runs with DROP_ON_ERR=1.
module tb_imm_encoder_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  in_type_sel = '0;
  logic [31:0] in_imm = '0, in_base = '0;
  logic        in_ready, out_valid, out_range_err, out_align_err;
  logic [31:0] out_instr;
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_range_err, d_out_align_err;
  logic        d_out_ready = 1'b1;
  logic [31:0] d_out_instr;
`ifdef ERR_COUNT_EN
  logic [7:0]  err_count, d_err_count;
`endif

  // The drop instance takes exactly the items the main instance accepts.
  assign d_in_valid = in_valid & in_ready;

  imm_encoder_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_type_sel(in_type_sel), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_range_err(out_range_err), .out_align_err(out_align_err)
`ifdef ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  imm_encoder_pipe #(.CNT_W(8), .DROP_ON_ERR(1'b1)) u_drop (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_type_sel(in_type_sel), .in_imm(in_imm), .in_base(in_base),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_instr(d_out_instr),
    .out_range_err(d_out_range_err), .out_align_err(d_out_align_err)
`ifdef ERR_COUNT_EN
    , .err_count(d_err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, d_outs = 0, errc = 0;
  bit rnd_ready = 1'b0;
  logic [33:0] exp_q[$], dexp_q[$];
  logic [33:0] prev = '0;
  bit stalled = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: field placement by masks and shifts, range by signed bounds.
  function automatic logic [33:0] model(input logic [2:0] t, input logic [31:0] imm,
                                        input logic [31:0] base);
    int signed v;
    logic [31:0] w;
    logic r, a;
    v = $signed(imm);
    w = base; r = 1'b1; a = 1'b0;
    case (t)
      3'd0: begin
        w = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
        r = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        r = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        r = (v < -4096) || (v > 4095);
        a = (imm & 32'h1) != 0;
      end
      3'd3: begin
        w = (imm & 32'hFFFF_F000) | (base & 32'hFFF);
        r = 1'b0;
        a = (imm & 32'hFFF) != 0;
      end
      3'd4: begin
        w = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        r = (v < -(1 << 20)) || (v > (1 << 20) - 1);
        a = (imm & 32'h1) != 0;
      end
      default: ;
    endcase
    return {w, r, a};
  endfunction

  function automatic logic [31:0] rnd_imm();
    logic [31:0] bnd [16] = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE, 32'hFFF,
                              32'h1000, 32'hFFFFF000, 32'hFFFFEFFF, 32'hFFFFE, 32'h100000,
                              32'hFFF00000, 32'hFFEFFFFE, 32'h0, 32'h1, 32'h7FFFF000};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return bnd[$urandom_range(0, 15)];
      default: return 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
    endcase
  endfunction

  // Inputs change 1 time unit after posedge; acceptance is judged at the negedge.
  task automatic send_e(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                        input logic [33:0] e);
    int n = 0;
    in_valid = 1'b1; in_type_sel = t; in_imm = imm; in_base = base;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
      @(negedge clk);
    end
    chk("accept", in_ready, 1'b1);
    if (in_ready) begin
      exp_q.push_back(e);
      if (!(e[1] | e[0])) dexp_q.push_back(e);
      else if (errc < 255) errc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
    send_e(t, imm, base, model(t, imm, base));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_main", exp_q.size(), 0);
    chk("drain_drop", dexp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", {out_instr, out_range_err, out_align_err}, prev);
      end
      if (out_valid && out_ready) begin
        chk("out_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          chk("out_word", {out_instr, out_range_err, out_align_err}, exp_q.pop_front());
      end
      if (d_out_valid && d_out_ready) begin
        d_outs++;
        chk("drop_pending", dexp_q.size() != 0, 1'b1);
        if (dexp_q.size() != 0)
          chk("drop_word", {d_out_instr, d_out_range_err, d_out_align_err}, dexp_q.pop_front());
      end
      stalled <= out_valid && !out_ready;
      prev    <= {out_instr, out_range_err, out_align_err};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_outs, t;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", {out_instr, out_range_err, out_align_err}, 34'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("rdy_after_edge", in_ready, 1'b1);

    // latency: visible two edges after the accept edge
    send_e(3'd0, 32'hFFFF_FFFF, 32'h13, {32'hFFF0_0013, 2'b00});
    @(negedge clk);
    chk("lat_s1_only", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    send_e(3'd2, 32'h800, 32'h63, {32'h0000_00E3, 2'b00});
    send_e(3'd2, 32'h801, 32'h63, {32'h0000_00E3, 2'b01});
    send_e(3'd3, 32'h1234_5000, 32'h37, {32'h1234_5037, 2'b00});
    send_e(3'd4, 32'h0010_0000, 32'h6F, {32'h8000_006F, 2'b10});
    send_e(3'd6, 32'h5, 32'hDEAD_BEEF, {32'hDEAD_BEEF, 2'b10});
    drain();

    // stall: two accepts fill both stages, then input closes
    out_ready = 1'b0;
    send(3'd0, 32'h11, 32'h13);
    send(3'd1, 32'hFFFF_FFF0, 32'h23);
    in_valid = 1'b1; in_type_sel = 3'd3; in_imm = 32'hABCD_E000; in_base = 32'h17;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd3, 32'hABCD_E000, 32'h17);
    send(3'd4, 32'hFFFF_F002, 32'h6F);
    drain();

    // drop instance: {ok, err, ok} gives two outputs
    base_outs = d_outs;
    send(3'd0, 32'h7FF, 32'h13);
    send(3'd1, 32'h800, 32'h23);
    send(3'd2, 32'hFFFF_F000, 32'h63);
    drain();
    chk("drop_count", d_outs - base_outs, 2);

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      t = $urandom_range(0, 9);
      if (t > 7) t -= 5;
      send(3'(t), rnd_imm(), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rnd_ready = 1'b0;
    drain();
`ifdef ERR_COUNT_EN
    chk("err_count", err_count, 8'(errc));
    chk("drop_err_count", d_err_count, 8'(errc));
    for (int i = 0; i < 260; i++) send(3'd7, 32'h0, 32'h0);
    drain();
    chk("err_count_sat", err_count, 8'd255);
`endif

    // reset with both stages full: flushed, nothing stale afterwards
    out_ready = 1'b0;
    send(3'd0, 32'h1, 32'h13);
    send(3'd0, 32'h2, 32'h13);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_drop_valid", d_out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    dexp_q.delete();
    errc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd1, 32'h7E5, 32'h0000_2023);
    send(3'd2, 32'hFFFF_FFFE, 32'h63);
    drain();
`ifdef ERR_COUNT_EN
    chk("err_count_after_rst", err_count, 8'(errc));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
